// File: rtl/aes_key_expand_ctrl_if.sv
// Key-load and round-key handshake bundle for aes_key_expand_ctrl.
interface aes_key_expand_ctrl_if;
  logic         key_in_valid;
  logic [31:0]  key_in_word;
  logic         key_in_ready;
  logic [127:0] rk;
  logic [3:0]   rk_round;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;
  logic         done;

  modport master (
    output key_in_valid, key_in_word, rk_ready,
    input  key_in_ready, rk, rk_round, rk_valid, busy, done
  );

  modport slave (
    input  key_in_valid, key_in_word, rk_ready,
    output key_in_ready, rk, rk_round, rk_valid, busy, done
  );
endinterface

// File: rtl/aes_key_expand_ctrl.sv
// Word-serial AES key expansion (128/192/256): one word per cycle into an NK-word
// window, round keys assembled four words at a time behind a valid/ready handshake.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX[in_byte];
endmodule

module aes_key_expand_ctrl #(
  parameter int KEY_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  aes_key_expand_ctrl_if.slave bus
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK_W    = 6'(NK);
  localparam logic [5:0] LAST_LD = 6'(NK - 1);
  localparam logic [5:0] LAST_W  = 6'(NW - 1);

  generate
    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_key_expand_ctrl: KEY_BITS must be 128, 192 or 256");
    end
  endgenerate

  typedef enum logic [1:0] {S_LOAD, S_EXPAND, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [5:0]         i_q, i_d;
  logic [NK-1:0][31:0] win_q, win_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [127:0]       asm_q, asm_d;
  logic [2:0]         asm_cnt_q, asm_cnt_d;
  logic [3:0]         rk_round_q, rk_round_d;
  logic               done_q, done_d;

  logic        rk_valid, key_ready, hs, load_acc, gen;
  logic [5:0]  phase;
  logic [31:0] prev, sub_in, sub_out, t, new_word;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // win_q[NK-1] is w[i-1], win_q[0] is w[i-NK]
  always_comb begin
    prev   = win_q[NK-1];
    phase  = i_q % NK_W;
    sub_in = (phase == 6'd0) ? {prev[23:0], prev[31:24]} : prev;
  end

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*g +: 8]),
      .out_byte (sub_out[8*g +: 8])
    );
  end

  always_comb begin
    if (phase == 6'd0)                  t = sub_out ^ {rcon_q, 24'h0};
    else if (NK == 8 && phase == 6'd4)  t = sub_out;
    else                                t = prev;
  end

  assign rk_valid  = (asm_cnt_q == 3'd4);
  assign key_ready = (state_q == S_LOAD) && (asm_cnt_q < 3'd4);
  assign hs        = rk_valid && bus.rk_ready;
  assign load_acc  = key_ready && bus.key_in_valid;
  assign gen       = (state_q == S_EXPAND) && (asm_cnt_q < 3'd4);
  assign new_word  = load_acc ? bus.key_in_word : (win_q[0] ^ t);

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    win_d      = win_q;
    rcon_d     = rcon_q;
    asm_d      = asm_q;
    asm_cnt_d  = asm_cnt_q;
    rk_round_d = rk_round_q;
    done_d     = 1'b0;
    if (hs) begin
      asm_cnt_d = 3'd0;
      if (state_q == S_DRAIN) begin
        state_d    = S_LOAD;
        i_d        = 6'd0;
        rcon_d     = 8'h01;
        rk_round_d = 4'd0;
        done_d     = 1'b1;
      end else begin
        rk_round_d = rk_round_q + 4'd1;
      end
    end else if (load_acc || gen) begin
      // Assembly shifts independently of the window so AES-192 keys straddle cleanly
      win_d     = {new_word, win_q[NK-1:1]};
      asm_d     = {asm_q[95:0], new_word};
      asm_cnt_d = asm_cnt_q + 3'd1;
      if (i_q != LAST_W) i_d = i_q + 6'd1;
      if (load_acc && i_q == LAST_LD) state_d = S_EXPAND;
      if (gen) begin
        if (phase == 6'd0) rcon_d = xtime(rcon_q);
        if (i_q == LAST_W) state_d = S_DRAIN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_LOAD;
      i_q        <= 6'd0;
      rcon_q     <= 8'h01;
      asm_q      <= '0;
      asm_cnt_q  <= 3'd0;
      rk_round_q <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      rcon_q     <= rcon_d;
      asm_q      <= asm_d;
      asm_cnt_q  <= asm_cnt_d;
      rk_round_q <= rk_round_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) win_q <= win_d;

  assign bus.key_in_ready = key_ready;
  assign bus.rk           = asm_q;
  assign bus.rk_round     = rk_round_q;
  assign bus.rk_valid     = rk_valid;
  assign bus.busy         = (state_q != S_LOAD) || (i_q != 6'd0);
  assign bus.done         = done_q;
endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Scoreboard bench for aes_key_expand_ctrl: three key sizes against an independent
// key-expansion model and the FIPS-197 reference round keys.
module tb_aes_key_expand_ctrl;
  typedef struct { logic [3:0] rnd; logic [127:0] key; } rk_t;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic        key_valid = 1'b0;
  logic [31:0] key_word = 32'h0;
  logic        rk_ready_t = 1'b0;

  aes_key_expand_ctrl_if b128();
  aes_key_expand_ctrl_if b192();
  aes_key_expand_ctrl_if b256();

  assign b128.key_in_valid = key_valid && (sel == 0);
  assign b192.key_in_valid = key_valid && (sel == 1);
  assign b256.key_in_valid = key_valid && (sel == 2);
  assign b128.key_in_word  = key_word;
  assign b192.key_in_word  = key_word;
  assign b256.key_in_word  = key_word;
  assign b128.rk_ready     = rk_ready_t && (sel == 0);
  assign b192.rk_ready     = rk_ready_t && (sel == 1);
  assign b256.rk_ready     = rk_ready_t && (sel == 2);

  aes_key_expand_ctrl #(.KEY_BITS(128)) u_dut128 (.clk(clk), .rst(rst), .bus(b128));
  aes_key_expand_ctrl #(.KEY_BITS(192)) u_dut192 (.clk(clk), .rst(rst), .bus(b192));
  aes_key_expand_ctrl #(.KEY_BITS(256)) u_dut256 (.clk(clk), .rst(rst), .bus(b256));

  logic [127:0] o_rk;
  logic [3:0]   o_round;
  logic         o_valid, o_ready, o_busy, o_done;

  always_comb begin
    o_rk = b128.rk; o_round = b128.rk_round; o_valid = b128.rk_valid;
    o_ready = b128.key_in_ready; o_busy = b128.busy; o_done = b128.done;
    if (sel == 1) begin
      o_rk = b192.rk; o_round = b192.rk_round; o_valid = b192.rk_valid;
      o_ready = b192.key_in_ready; o_busy = b192.busy; o_done = b192.done;
    end else if (sel == 2) begin
      o_rk = b256.rk; o_round = b256.rk_round; o_valid = b256.rk_valid;
      o_ready = b256.key_in_ready; o_busy = b256.busy; o_done = b256.done;
    end
  end

  int   n_checks = 0;
  int   n_errors = 0;
  rk_t  exp_q[$];
  rk_t  obs_q[$];
  rk_t  stall_q[$];
  int   obs_cyc[$];
  int   done_cnt = 0;
  logic [7:0] sb_m [256];

  // S-box derived from the GF(2^8) inverse plus affine map, not from a table
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] b);
    logic [7:0] inv = 8'h00;
    for (int x = 1; x < 256; x++) if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_m[w[31:24]], sb_m[w[23:16]], sb_m[w[15:8]], sb_m[w[7:0]]};
  endfunction

  task automatic build_expected(input int kb, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nk = kb / 32;
    int nw = 4 * (nk + 7);
    rk_t e;
    exp_q.delete();
    for (int k = 0; k < nk; k++) w[k] = key[255-32*k -: 32];
    for (int k = nk; k < nw; k++) begin
      t = w[k-1];
      if (k % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && k % 8 == 4) begin
        t = subw(t);
      end
      w[k] = w[k-nk] ^ t;
    end
    for (int r = 0; r < nw / 4; r++) begin
      e.rnd = 4'(r);
      e.key = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_q.push_back(e);
    end
  endtask

  // Drives one key and records every handshaked round key; no checking here
  task automatic run(input int kb, input logic [255:0] key, input bit rnd_valid,
                     input int stall_round, input int abort_round, input int budget,
                     output bit timed_out);
    int  nk = kb / 32;
    int  widx = 0;
    int  stall_left = 20;
    int  end_at = -1;
    rk_t s;
    sel = (kb == 128) ? 0 : (kb == 192) ? 1 : 2;
    build_expected(kb, key);
    obs_q.delete(); obs_cyc.delete(); stall_q.delete();
    done_cnt  = 0;
    timed_out = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (o_done) done_cnt++;
      if (end_at == cyc) begin timed_out = 1'b0; break; end
      if (o_done && end_at < 0) end_at = cyc + 8;
      if (abort_round >= 0 && o_valid && o_round == 4'(abort_round)) begin
        rst = 1'b1; rk_ready_t = 1'b1; key_valid = 1'b0; timed_out = 1'b0;
        break;
      end
      rk_ready_t = 1'b1;
      s.rnd = o_round;
      s.key = o_rk;
      if (stall_round >= 0 && o_valid && o_round == 4'(stall_round) && stall_left > 0) begin
        rk_ready_t = 1'b0;
        stall_left--;
        stall_q.push_back(s);
      end
      if (o_valid && rk_ready_t) begin obs_q.push_back(s); obs_cyc.push_back(cyc); end
      if (widx < nk) begin
        key_valid = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        key_word  = key_valid ? key[255-32*widx -: 32] : $urandom;
        if (key_valid && o_ready) widx++;
      end else begin
        key_valid = (rnd_valid && end_at < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        key_word  = $urandom;
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b0; rk_ready_t = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_checks++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_round !== 4'd0 || o_rk !== 128'h0) begin
        n_errors++;
        $display("FAIL reset_state dut=%0d got valid=%b busy=%b done=%b round=%0d rk=%h want all zero",
                 s, o_valid, o_busy, o_done, o_round, o_rk);
      end
      n_checks++;
      if (o_ready !== 1'b1) begin
        n_errors++; $display("FAIL reset_key_in_ready dut=%0d got=%b want=1", s, o_ready);
      end
    end
  endtask

  task automatic test_aes128();
    bit to; rk_t o, e;
    run(128, K128, 1'b0, -1, -1, 400, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL aes128_timeout got=%b want=0", to); end
    n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL aes128_done_count got=%0d want=1", done_cnt); end
    n_checks++; if (obs_q.size() !== 11) begin n_errors++; $display("FAIL aes128_rounds got=%0d want=11", obs_q.size()); end
    if (obs_q.size() == 11) begin
      n_checks++; if (obs_q[1].key !== R128_1) begin n_errors++; $display("FAIL aes128_round1 got=%h want=%h", obs_q[1].key, R128_1); end
      n_checks++; if (obs_q[10].key !== R128_10) begin n_errors++; $display("FAIL aes128_round10 got=%h want=%h", obs_q[10].key, R128_10); end
    end
    for (int k = 1; k < obs_cyc.size(); k++) begin
      n_checks++;
      if (obs_cyc[k] - obs_cyc[k-1] !== 5) begin
        n_errors++; $display("FAIL aes128_spacing round=%0d got=%0d want=5", k, obs_cyc[k] - obs_cyc[k-1]);
      end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o.rnd !== e.rnd || o.key !== e.key) begin
        n_errors++; $display("FAIL aes128_key got=%0d:%h want=%0d:%h", o.rnd, o.key, e.rnd, e.key);
      end
    end
    n_checks++;
    if (o_busy !== 1'b0 || o_ready !== 1'b1) begin
      n_errors++; $display("FAIL aes128_idle got busy=%b ready=%b want busy=0 ready=1", o_busy, o_ready);
    end
  endtask

  task automatic test_aes192();
    bit to; rk_t o, e;
    run(192, K192, 1'b0, -1, -1, 400, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL aes192_timeout got=%b want=0", to); end
    n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL aes192_done_count got=%0d want=1", done_cnt); end
    n_checks++; if (obs_q.size() !== 13) begin n_errors++; $display("FAIL aes192_rounds got=%0d want=13", obs_q.size()); end
    if (obs_q.size() == 13) begin
      n_checks++; if (obs_q[12].key !== R192_12) begin n_errors++; $display("FAIL aes192_round12 got=%h want=%h", obs_q[12].key, R192_12); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o.rnd !== e.rnd || o.key !== e.key) begin
        n_errors++; $display("FAIL aes192_key got=%0d:%h want=%0d:%h", o.rnd, o.key, e.rnd, e.key);
      end
    end
  endtask

  task automatic test_aes256();
    bit to; rk_t o, e;
    run(256, K256, 1'b0, -1, -1, 400, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL aes256_timeout got=%b want=0", to); end
    n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL aes256_done_count got=%0d want=1", done_cnt); end
    n_checks++; if (obs_q.size() !== 15) begin n_errors++; $display("FAIL aes256_rounds got=%0d want=15", obs_q.size()); end
    if (obs_q.size() == 15) begin
      n_checks++; if (obs_q[14].key !== R256_14) begin n_errors++; $display("FAIL aes256_round14 got=%h want=%h", obs_q[14].key, R256_14); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o.rnd !== e.rnd || o.key !== e.key) begin
        n_errors++; $display("FAIL aes256_key got=%0d:%h want=%0d:%h", o.rnd, o.key, e.rnd, e.key);
      end
    end
  endtask

  task automatic test_stall();
    bit to; rk_t o, e; rk_t r3;
    run(128, K128, 1'b0, 3, -1, 500, to);
    r3 = exp_q[3];
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL stall_timeout got=%b want=0", to); end
    n_checks++; if (stall_q.size() !== 20) begin n_errors++; $display("FAIL stall_cycles got=%0d want=20", stall_q.size()); end
    foreach (stall_q[k]) begin
      n_checks++;
      if (stall_q[k].rnd !== 4'd3 || stall_q[k].key !== r3.key) begin
        n_errors++; $display("FAIL stall_hold cycle=%0d got=%0d:%h want=3:%h", k, stall_q[k].rnd, stall_q[k].key, r3.key);
      end
    end
    n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL stall_done_count got=%0d want=1", done_cnt); end
    n_checks++; if (obs_q.size() !== 11) begin n_errors++; $display("FAIL stall_rounds got=%0d want=11", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o.rnd !== e.rnd || o.key !== e.key) begin
        n_errors++; $display("FAIL stall_key got=%0d:%h want=%0d:%h", o.rnd, o.key, e.rnd, e.key);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to; rk_t o, e;
    run(128, K128, 1'b0, -1, 5, 400, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL abort_reach_round5 got_timeout=%b want=0", to); end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_round !== 4'd0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_state got valid=%b ready=%b round=%0d busy=%b done=%b want 0 1 0 0 0",
               o_valid, o_ready, o_round, o_busy, o_done);
    end
    run(128, K128, 1'b0, -1, -1, 400, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL abort_rerun_timeout got=%b want=0", to); end
    n_checks++;
    if (obs_q.size() == 0 || obs_q[0].key !== K128[255:128]) begin
      n_errors++; $display("FAIL abort_round0 got=%h want=%h", (obs_q.size() > 0) ? obs_q[0].key : 128'h0, K128[255:128]);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o.rnd !== e.rnd || o.key !== e.key) begin
        n_errors++; $display("FAIL abort_rerun_key got=%0d:%h want=%0d:%h", o.rnd, o.key, e.rnd, e.key);
      end
    end
  endtask

  task automatic test_random_valid();
    bit to; rk_t o, e;
    run(128, K128, 1'b1, -1, -1, 1000, to);
    n_checks++; if (to !== 1'b0) begin n_errors++; $display("FAIL rndvalid_timeout got=%b want=0", to); end
    n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL rndvalid_done_count got=%0d want=1", done_cnt); end
    n_checks++; if (obs_q.size() !== 11) begin n_errors++; $display("FAIL rndvalid_rounds got=%0d want=11", obs_q.size()); end
    if (obs_q.size() == 11) begin
      n_checks++; if (obs_q[10].key !== R128_10) begin n_errors++; $display("FAIL rndvalid_round10 got=%h want=%h", obs_q[10].key, R128_10); end
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      n_checks++;
      if (o.rnd !== e.rnd || o.key !== e.key) begin
        n_errors++; $display("FAIL rndvalid_key got=%0d:%h want=%0d:%h", o.rnd, o.key, e.rnd, e.key);
      end
    end
  endtask

  initial begin
    for (int b = 0; b < 256; b++) sb_m[b] = sbox_calc(8'(b));
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256();
    test_stall();
    test_reset_mid();
    test_random_valid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
